// File: rtl/fir_pkg.sv
// FIR shared definitions: default tap/sample counts and the issue-FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fir_pkg;

  localparam int NUM_TAPS    = 11;
  localparam int NUM_SAMPLES = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE_TAP = 2'd1,
    ISSUE_X   = 2'd2,
    WAIT_OUT  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/fir_stream_feeder_if.sv
// Memory read port plus AXI-stream output bundle between feeder and its neighbours.
// Latency: n/a (wires only).
// Backpressure: m_tready from the stream consumer; memory side has no backpressure.
// Ports: mem_rd_en/mem_rd_addr (request), mem_rd_valid/mem_rd_data (in-order response),
//        m_tvalid/m_tdata/m_tlast (stream out), m_tready (stream ready).
interface fir_stream_feeder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  import fir_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tready;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_valid, mem_rd_data,
    output m_tvalid, m_tdata, m_tlast,
    input  m_tready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_valid, mem_rd_data,
    input  m_tvalid, m_tdata, m_tlast,
    output m_tready
  );

endinterface

// File: rtl/fir_prefetch_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry.
// Latency: a push is visible on head the cycle after it is written.
// Backpressure: push while full is dropped unless a pop frees the slot in the same cycle.
// Ports: push/push_data (write), pop (read), head, empty, full, count.
module fir_prefetch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import fir_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] store [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop of a full FIFO frees the slot this push lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_stream_feeder.sv
// Fetches NUM_TAPS coefficients then NUM_SAMPLES samples from memory and streams them out.
// Latency: first read the cycle after start; first beat one cycle after first read response.
// Backpressure: reads are credit-limited so FIFO occupancy plus in-flight reads never exceed FIFO_DEPTH.
// Ports: clk, rst, ap_start, tap_base, x_base, busy, done, bus (memory read + stream master).
module fir_stream_feeder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int NUM_TAPS    = fir_pkg::NUM_TAPS,
  parameter int NUM_SAMPLES = fir_pkg::NUM_SAMPLES,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
  input  logic [ADDR_W-1:0] tap_base,
  input  logic [ADDR_W-1:0] x_base,
  output logic              busy,
  output logic              done,
  fir_stream_feeder_if.master bus
);
  import fir_pkg::*;

  localparam int TOTAL = NUM_TAPS + NUM_SAMPLES;
  localparam int BW    = $clog2(TOTAL);
  localparam int CW    = $clog2(FIFO_DEPTH+1);

  issue_state_t      state, state_nxt;
  logic [ADDR_W-1:0] tap_base_q, x_base_q;
  logic [BW-1:0]     issue_cnt, beat_cnt;
  logic [CW-1:0]     inflight, fifo_count;
  logic [CW:0]       outstanding;
  logic              fifo_empty, fifo_full;
  logic              credit_ok, rsp_ok, push, pop, last_beat;
  logic              start_ok, rd_en, phase_end, done_q;

  // The done cycle itself is IDLE but must not accept a restart.
  assign start_ok    = ap_start && (state == IDLE) && !done_q;
  assign outstanding = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok   = outstanding < (CW+1)'(FIFO_DEPTH);
  // A response with nothing outstanding is spurious and is dropped.
  assign rsp_ok      = bus.mem_rd_valid && (inflight != '0);
  assign push        = rsp_ok && (!fifo_full || pop);
  assign pop         = bus.m_tvalid && bus.m_tready;
  assign last_beat   = (beat_cnt == BW'(TOTAL-1));

  assign busy             = (state != IDLE);
  assign done             = done_q;
  assign bus.mem_rd_en    = rd_en;
  assign bus.mem_rd_addr  = ((state == ISSUE_X) ? x_base_q : tap_base_q) + ADDR_W'(issue_cnt);
  assign bus.m_tvalid     = !fifo_empty;
  assign bus.m_tlast      = bus.m_tvalid && last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    phase_end = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nxt = ISSUE_TAP;
      ISSUE_TAP: begin
        rd_en     = credit_ok;
        phase_end = (issue_cnt == BW'(NUM_TAPS-1));
        if (rd_en && phase_end) state_nxt = ISSUE_X;
      end
      ISSUE_X: begin
        rd_en     = credit_ok;
        phase_end = (issue_cnt == BW'(NUM_SAMPLES-1));
        if (rd_en && phase_end) state_nxt = WAIT_OUT;
      end
      WAIT_OUT: if (pop && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_base_q <= '0;
      x_base_q   <= '0;
      issue_cnt  <= '0;
      beat_cnt   <= '0;
      inflight   <= '0;
      done_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        tap_base_q <= tap_base;
        x_base_q   <= x_base;
      end
      if (rd_en) issue_cnt <= phase_end ? '0 : issue_cnt + BW'(1);
      if (pop)   beat_cnt  <= last_beat ? '0 : beat_cnt + BW'(1);
      case ({rd_en, rsp_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      done_q <= pop && last_beat;
    end
  end

  fir_prefetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.mem_rd_data),
    .pop       (pop),
    .head      (bus.m_tdata),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule
